// File: rtl/schem_pkg.sv
// Shared types, constants and golden function for the schematic-test stimulus driver.
// Optional build macro: SCHEM_STIM_LFSR_EN (scrambled LFSR vector order instead of ascending).
package schem_pkg;

  localparam int unsigned STIM_W = 4;
  localparam int unsigned NVEC   = 1 << STIM_W;

  // FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef logic [2:0] state_t;

  // Fibonacci LFSR x^4+x^3+1: feedback from bits 3 and 2, shift towards the MSB.
  localparam logic [STIM_W-1:0] LFSR_SEED = 4'b0001;
  localparam logic [STIM_W-1:0] LFSR_TAPS = 4'b1100;
  // Last nonzero state before the sequence would return to the seed.
  localparam logic [STIM_W-1:0] LFSR_WRAP = 4'b1000;

`ifdef SCHEM_STIM_LFSR_EN
  localparam logic [STIM_W-1:0] FIRST_VEC = LFSR_SEED;
  localparam logic [STIM_W-1:0] LAST_VEC  = 4'b0000;
`else
  localparam logic [STIM_W-1:0] FIRST_VEC = 4'b0000;
  localparam logic [STIM_W-1:0] LAST_VEC  = 4'b1111;
`endif

  // Golden response of the schematic block: (in0&in1)|(in2&in3)
  function automatic logic schem_expect(input logic [STIM_W-1:0] v);
    return (v[0] & v[1]) | (v[2] & v[3]);
  endfunction

  // One LFSR step
  function automatic logic [STIM_W-1:0] schem_lfsr_step(input logic [STIM_W-1:0] v);
    return {v[2:0], ^(v & LFSR_TAPS)};
  endfunction

  // Vector that follows v in the active ordering
  function automatic logic [STIM_W-1:0] schem_next_vec(input logic [STIM_W-1:0] v);
`ifdef SCHEM_STIM_LFSR_EN
    // The all-zero vector is appended after the 15 nonzero LFSR states.
    if (v == LFSR_WRAP) begin
      return 4'b0000;
    end else begin
      return schem_lfsr_step(v);
    end
`else
    return v + 4'd1;
`endif
  endfunction

endpackage

// File: rtl/schem_ref_model.sv
// Combinational golden model of the schematic block: vector in, expected output bit out.
module schem_ref_model
  import schem_pkg::*;
(
  input  logic [STIM_W-1:0] vec,
  output logic              exp_out
);

  // Evaluate the golden function for the vector currently under test
  always_comb begin
    exp_out = schem_expect(vec);
  end

endmodule

// File: rtl/schem_stim_driver.sv
// Self-checking stimulus driver: sweeps all 16 vectors into the schematic block,
// compares each response with the golden model and reports pass/fail, error count
// and the first failing vector.
// Optional build macro: SCHEM_STIM_LFSR_EN selects scrambled LFSR vector order.
// SETTLE must lie in 1..15 (it is loaded into a 4-bit settle counter).
module schem_stim_driver
  import schem_pkg::*;
#(
  parameter int unsigned SETTLE = 2
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dut_out,
  output logic [STIM_W-1:0] stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_count,
  output logic              fail_valid,
  output logic [STIM_W-1:0] first_fail
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t            state_r;
  logic [STIM_W-1:0] vec_r;
  logic [3:0]        cnt_r;
  logic              exp_s;
  logic              mismatch_s;
  logic              last_s;

  schem_ref_model u_ref (
    .vec     (vec_r),
    .exp_out (exp_s)
  );

  // Compare the sampled response and detect the final vector of the run
  always_comb begin
    mismatch_s = dut_out ^ exp_s;
    last_s     = (vec_r == LAST_VEC);
  end

  // Run sequencing, result accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      vec_r      <= 4'd0;
      cnt_r      <= 4'd0;
      stim       <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      fail_valid <= 1'b0;
      first_fail <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // The done-pulse cycle still belongs to the finished run, so a start
          // arriving then is dropped rather than launching a new run.
          if (start && !done) begin
            err_count  <= 5'd0;
            fail_valid <= 1'b0;
            first_fail <= 4'd0;
            pass       <= 1'b0;
            vec_r      <= FIRST_VEC;
            busy       <= 1'b1;
            state_r    <= ST_DRIVE;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          stim    <= vec_r;
          cnt_r   <= SETTLE_M1;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_CHECK;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
          end
        end
        ST_CHECK: begin
          // At most 16 mismatches per run, so the 5-bit counter never wraps.
          if (mismatch_s) begin
            err_count <= err_count + 5'd1;
            if (!fail_valid) begin
              first_fail <= vec_r;
              fail_valid <= 1'b1;
            end else begin
              fail_valid <= 1'b1;
            end
          end else begin
            err_count <= err_count;
          end
          if (last_s) begin
            state_r <= ST_DONE;
          end else begin
            vec_r   <= schem_next_vec(vec_r);
            state_r <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          pass    <= (err_count == 5'd0);
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_schem_stim_driver.sv
// Bench for schem_stim_driver: three driver instances (SETTLE = 2, 1, 15), each
// attached to a behavioural registered schematic block whose output can be
// correct, stuck at 0 or inverted.
module tb_schem_stim_driver;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        start_v = 3'b000;
  logic [2:0]        dut_out_v;
  logic [2:0][3:0]   stim_v;
  logic [2:0]        busy_v, done_v, pass_v, fv_v;
  logic [2:0][4:0]   err_v;
  logic [2:0][3:0]   ff_v;
  logic [2:0][3:0]   blk_in;
  int                mode = 0;   // 0 correct, 1 stuck-at-0, 2 inverted

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef SCHEM_STIM_LFSR_EN
  localparam logic [3:0] FF_ZERO = 4'd3;   // first LFSR vector whose golden output is 1
  localparam logic [3:0] FF_INV  = 4'd1;   // LFSR seed
  localparam logic [3:0] END_VEC = 4'd0;
`else
  localparam logic [3:0] FF_ZERO = 4'd3;
  localparam logic [3:0] FF_INV  = 4'd0;
  localparam logic [3:0] END_VEC = 4'd15;
`endif

  schem_stim_driver #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .dut_out(dut_out_v[0]), .stim(stim_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
    .fail_valid(fv_v[0]), .first_fail(ff_v[0]));

  schem_stim_driver #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .dut_out(dut_out_v[1]), .stim(stim_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
    .fail_valid(fv_v[1]), .first_fail(ff_v[1]));

  schem_stim_driver #(.SETTLE(15)) u_dut15 (
    .clk(clk), .rst(rst), .start(start_v[2]), .dut_out(dut_out_v[2]), .stim(stim_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
    .fail_valid(fv_v[2]), .first_fail(ff_v[2]));

  // Registered input stage of the schematic block under test
  always_ff @(posedge clk) begin
    blk_in <= stim_v;
  end

  // Schematic block output with selectable fault
  always_comb begin
    dut_out_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      dut_out_v[i] = (mode == 1) ? 1'b0 :
        (((blk_in[i][0] & blk_in[i][1]) | (blk_in[i][2] & blk_in[i][3])) ^ (mode == 2));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_idle_cleared(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, " stim"},  32'(stim_v[i]), 32'd0);
      chk({tag, " busy"},  32'(busy_v[i]), 32'd0);
      chk({tag, " done"},  32'(done_v[i]), 32'd0);
      chk({tag, " pass"},  32'(pass_v[i]), 32'd0);
      chk({tag, " err"},   32'(err_v[i]),  32'd0);
      chk({tag, " fv"},    32'(fv_v[i]),   32'd0);
      chk({tag, " ff"},    32'(ff_v[i]),   32'd0);
    end
  endtask

  typedef struct {
    int         idx;
    int         md;
    bit         poke;
    logic [4:0] err;
    logic [3:0] ff;
    bit         fv;
    bit         pass;
    int         lat;
  } vec_t;

  vec_t tbl[8];

  // One full run on instance v.idx, checking latency, coverage, results and start-ignore
  task automatic do_run(input vec_t v);
    int cyc;
    int extra_done;
    logic [15:0] seen;
    mode = v.md;
    @(negedge clk);
    start_v[v.idx] = 1'b1;
    @(negedge clk);
    start_v[v.idx] = 1'b0;
    cyc  = 0;
    seen = 16'h0000;
    chk("busy_after_start", 32'(busy_v[v.idx]), 32'd1);
    chk("pass_cleared",     32'(pass_v[v.idx]), 32'd0);
    chk("err_cleared",      32'(err_v[v.idx]),  32'd0);
    while (!done_v[v.idx] && cyc < 400) begin
      @(negedge clk);
      cyc++;
      seen[stim_v[v.idx]] = 1'b1;
      start_v[v.idx] = v.poke && (cyc == 10 || cyc >= v.lat - 1);
    end
    chk("done_latency",   32'(cyc),             32'(v.lat));
    chk("busy_at_done",   32'(busy_v[v.idx]),   32'd0);
    chk("err_count",      32'(err_v[v.idx]),    32'(v.err));
    chk("fail_valid",     32'(fv_v[v.idx]),     32'(v.fv));
    chk("first_fail",     32'(ff_v[v.idx]),     32'(v.ff));
    chk("pass",           32'(pass_v[v.idx]),   32'(v.pass));
    chk("all_vectors",    32'(seen),            32'h0000FFFF);
    chk("stim_end",       32'(stim_v[v.idx]),   32'(END_VEC));
    @(negedge clk);
    start_v[v.idx] = 1'b0;
    chk("done_one_cycle", 32'(done_v[v.idx]),   32'd0);
    extra_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_v[v.idx] || busy_v[v.idx]) extra_done++;
    end
    chk("no_restart",     32'(extra_done),      32'd0);
    chk("pass_holds",     32'(pass_v[v.idx]),   32'(v.pass));
    chk("err_holds",      32'(err_v[v.idx]),    32'(v.err));
  endtask

  initial begin
    int wait_cyc;
    //           idx md poke err    ff       fv    pass  lat
    tbl[0] = '{0, 0, 1'b0, 5'd0,  4'd0,    1'b0, 1'b1, 65};
    tbl[1] = '{0, 1, 1'b0, 5'd7,  FF_ZERO, 1'b1, 1'b0, 65};
    tbl[2] = '{0, 2, 1'b0, 5'd16, FF_INV,  1'b1, 1'b0, 65};
    tbl[3] = '{0, 0, 1'b1, 5'd0,  4'd0,    1'b0, 1'b1, 65};
    tbl[4] = '{1, 0, 1'b0, 5'd0,  4'd0,    1'b0, 1'b1, 49};
    tbl[5] = '{2, 0, 1'b0, 5'd0,  4'd0,    1'b0, 1'b1, 273};
    tbl[6] = '{1, 2, 1'b0, 5'd16, FF_INV,  1'b1, 1'b0, 49};
    tbl[7] = '{2, 1, 1'b0, 5'd7,  FF_ZERO, 1'b1, 1'b0, 273};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_cleared("reset");

    // start together with rst: reset wins
    start_v = 3'b111;
    @(negedge clk);
    rst = 1'b0;
    start_v = 3'b000;
    repeat (3) @(negedge clk);
    chk("start_with_rst_busy", 32'(busy_v), 32'd0);

    // Table-driven runs
    for (int t = 0; t < 8; t++) begin
      do_run(tbl[t]);
    end

    // Mid-run reset at vector 8 while waiting, then a clean rerun
    mode = 2;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_cyc = 0;
    while (stim_v[0] != 4'd8 && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("reached_vec8", 32'(stim_v[0] == 4'd8), 32'd1);
`ifndef SCHEM_STIM_LFSR_EN
    chk("err_before_rst", 32'(err_v[0]), 32'd8);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_cleared("midrun_rst");
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'(busy_v[0]), 32'd0);
    do_run(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
